crc_frame_check: RTL and testbench

- Receive-side Ethernet FCS checker; sits directly downstream of the byte-wide receive datapath and consumes the same CRC32 recurrence as lfsr_crc.
- Accepts a byte stream that includes the 4-byte FCS, strips the FCS, and forwards payload bytes.
- Flags the last payload byte as bad when the CRC residue mismatches or the frame is a runt.
- Emits per-frame good/bad status pulses.

---
 rtl/crc_frame_check_pkg.sv | 34 +++
 rtl/crc_frame_check_delay.sv | 41 ++++
 rtl/crc_frame_check.sv | 132 +++++++++++++
 tb/tb_crc_frame_check.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/crc_frame_check_pkg.sv
// Shared Ethernet CRC32 constants and the reflected byte-step recurrence,
// used by the receive FCS checker and the transmit FCS inserter.
package crc_frame_check_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    // Poly is given in normal form; the LSB-first datapath needs it bit-reversed.
    function automatic logic [31:0] crc32_byte_step_poly(input logic [31:0] state,
                                                         input logic [7:0]  data,
                                                         input logic [31:0] poly);
        logic [31:0] rpoly;
        logic [31:0] s;
        for (int i = 0; i < 32; i++) begin
            rpoly[i] = poly[31-i];
        end
        s = state;
        for (int i = 0; i < 8; i++) begin
            if (s[0] ^ data[i]) begin
                s = (s >> 1) ^ rpoly;
            end else begin
                s = s >> 1;
            end
        end
        return s;
    endfunction

    function automatic logic [31:0] crc32_byte_step(input logic [31:0] state,
                                                    input logic [7:0]  data);
        return crc32_byte_step_poly(state, data, CRC32_POLY);
    endfunction

endpackage

// File: rtl/crc_frame_check_delay.sv
// Byte delay line holding the trailing FCS bytes; head_o is the oldest byte
// once full. A flush discards the contents so the FCS is never forwarded.
module crc_frame_check_delay #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       flush_i,
    input  logic [7:0] data_i,
    output logic       full_o,
    output logic [7:0] head_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    dat_q [DEPTH];
    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else if (push_i) begin
            // Always shift: when full the oldest byte drops out of the far end.
            dat_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                dat_q[i] <= dat_q[i-1];
            end
            if (count_q != CW'(DEPTH)) begin
                count_q <= count_q + CW'(1);
            end
        end
    end

    assign full_o = (count_q == CW'(DEPTH));
    assign head_o = dat_q[DEPTH-1];

endmodule

// File: rtl/crc_frame_check.sv
// Receive FCS checker: strips the trailing FCS, flags bad/runt frames on the last payload byte.
// CRC_FRAME_CHECK_STATS_EN adds saturating good/bad frame counters.
module crc_frame_check
    import crc_frame_check_pkg::*;
#(
    parameter logic [31:0] CRC_INIT    = CRC32_INIT,
    parameter logic [31:0] CRC_POLY    = CRC32_POLY,
    parameter logic [31:0] CRC_RESIDUE = CRC32_RESIDUE,
    parameter int          FCS_BYTES   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_last,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        m_user,
    output logic        stat_good,
    output logic        stat_bad
`ifdef CRC_FRAME_CHECK_STATS_EN
    ,
    output logic [31:0] stat_good_count,
    output logic [31:0] stat_bad_count
`endif
);

    logic [31:0] crc_q, crc_d, crc_next;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_valid_q, m_valid_d;
    logic        m_last_q, m_last_d;
    logic        m_user_q, m_user_d;
    logic        stat_good_q, stat_good_d;
    logic        stat_bad_q, stat_bad_d;
    logic        accept, frame_end, bad;
    logic        dl_full;
    logic [7:0]  dl_head;

    assign s_ready   = !m_valid_q || m_ready;
    assign accept    = s_valid && s_ready;
    assign frame_end = accept && s_last;
    assign crc_next  = crc32_byte_step_poly(crc_q, s_data, CRC_POLY);
    // A frame ending before the line is full carried no payload beyond the FCS.
    assign bad       = (crc_next != CRC_RESIDUE) || !dl_full;

    crc_frame_check_delay #(
        .DEPTH (FCS_BYTES)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .flush_i (frame_end),
        .data_i  (s_data),
        .full_o  (dl_full),
        .head_o  (dl_head)
    );

    always_comb begin
        crc_d       = crc_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_user_d    = m_user_q;
        stat_good_d = frame_end && !bad;
        stat_bad_d  = frame_end && bad;

        if (accept) begin
            crc_d = s_last ? CRC_INIT : crc_next;
        end

        if (accept && dl_full) begin
            m_data_d  = dl_head;
            m_valid_d = 1'b1;
            m_last_d  = s_last;
            m_user_d  = s_last && bad;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q       <= CRC_INIT;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_user_q    <= 1'b0;
            stat_good_q <= 1'b0;
            stat_bad_q  <= 1'b0;
        end else begin
            crc_q       <= crc_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_user_q    <= m_user_d;
            stat_good_q <= stat_good_d;
            stat_bad_q  <= stat_bad_d;
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign m_user    = m_user_q;
    assign stat_good = stat_good_q;
    assign stat_bad  = stat_bad_q;

`ifdef CRC_FRAME_CHECK_STATS_EN
    logic [31:0] good_cnt_q, bad_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            if (stat_good_q && (good_cnt_q != 32'hFFFFFFFF)) begin
                good_cnt_q <= good_cnt_q + 32'd1;
            end
            if (stat_bad_q && (bad_cnt_q != 32'hFFFFFFFF)) begin
                bad_cnt_q <= bad_cnt_q + 32'd1;
            end
        end
    end

    assign stat_good_count = good_cnt_q;
    assign stat_bad_count  = bad_cnt_q;
`endif

endmodule

// File: tb/tb_crc_frame_check.sv
// Scoreboard bench for crc_frame_check: driver queues expected beats/status, monitor pops and compares.
module tb_crc_frame_check;
    import crc_frame_check_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       s_last = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic       m_last;
    logic       m_user;
    logic       stat_good;
    logic       stat_bad;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_q[$];
    bit    stat_q[$];
    logic [7:0] frm[$];
    bit    toggle_en = 1'b0;
    bit    mon_en = 1'b0;

    crc_frame_check dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .m_user    (m_user),
        .stat_good (stat_good),
        .stat_bad  (stat_bad)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // m_ready changes just after each rising edge so it is stable at the falling edge.
    always @(posedge clk) begin
        #2;
        m_ready = toggle_en ? ~m_ready : 1'b1;
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    logic       stall_seen = 1'b0;
    logic [7:0] stall_dat  = '0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_seen) begin
                check("stall_valid_held", {31'd0, m_valid}, 32'd1);
                check("stall_data_held", {24'd0, m_data}, {24'd0, stall_dat});
            end
            stall_seen = m_valid && !m_ready;
            stall_dat  = m_data;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {24'd0, m_data}, 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", {24'd0, m_data}, {24'd0, e.d});
                    check("beat_last", {31'd0, m_last}, {31'd0, e.l});
                    if (e.l) check("beat_user", {31'd0, m_user}, {31'd0, e.u});
                end
            end
            if (stat_good || stat_bad) begin
                if (stat_q.size() == 0) begin
                    check("unexpected_status", {30'd0, stat_good, stat_bad}, 32'hFFFF_FFFF);
                end else begin
                    bit g;
                    g = stat_q.pop_front();
                    check("status_good", {31'd0, stat_good}, {31'd0, g});
                    check("status_bad", {31'd0, stat_bad}, {31'd0, !g});
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the byte is accepted.
    task automatic send(input logic [7:0] d, input logic l);
        bit acc;
        int budget;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        budget  = 0;
        acc     = 1'b0;
        while (!acc && budget < 200) begin
            acc = s_ready;
            @(negedge clk);
            budget++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Sends frm[]; expects payload beats (all but last 4 bytes) and a status pulse.
    task automatic run_frame(input bit good, input int gap_every);
        int n;
        n = frm.size();
        if (n >= 5) begin
            for (int i = 0; i < n - 4; i++) begin
                beat_t b;
                b.d = frm[i];
                b.l = (i == n - 5);
                b.u = !good;
                exp_q.push_back(b);
            end
        end
        stat_q.push_back(good);
        for (int i = 0; i < n; i++) begin
            send(frm[i], i == n - 1);
            if (gap_every != 0 && (i % gap_every) == 1 && i != n - 1) idle(1);
        end
    endtask

    task automatic load_good();
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_last", {31'd0, m_last}, 32'd0);
        check("rst_m_user", {31'd0, m_user}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        check("rst_stats", {30'd0, stat_good, stat_bad}, 32'd0);
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);
        mon_en = 1'b1;

        // Good frame
        load_good();
        run_frame(1'b1, 0);
        idle(4);

        // Corrupted FCS
        load_good();
        frm[12] = 8'hCA;
        run_frame(1'b0, 0);
        idle(4);

        // Runts: 4-byte and 1-byte frames
        frm = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        run_frame(1'b0, 0);
        frm = '{8'h55};
        run_frame(1'b0, 0);
        idle(4);

        // Backpressure with input gaps
        toggle_en = 1'b1;
        load_good();
        run_frame(1'b1, 3);
        idle(6);
        toggle_en = 1'b0;
        idle(4);

        // Back-to-back good frames
        load_good();
        run_frame(1'b1, 0);
        load_good();
        run_frame(1'b1, 0);
        idle(4);

        // Reset after 6 bytes: first two payload bytes already forwarded
        for (int i = 0; i < 2; i++) begin
            beat_t b;
            b.d = 8'h31 + 8'(i);
            b.l = 1'b0;
            b.u = 1'b0;
            exp_q.push_back(b);
        end
        load_good();
        for (int i = 0; i < 6; i++) send(frm[i], 1'b0);
        s_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        load_good();
        run_frame(1'b1, 0);
        idle(10);

        check("beats_left", exp_q.size(), 32'd0);
        check("status_left", stat_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
